riscv_branch_unit: RTL and testbench
====================================

# riscv_branch_unit

Parametrised branch resolution unit for the execute stage. Evaluates the six RV64 conditional-branch comparisons on XLEN-wide operands and registers the outcome. Holds a direct-mapped table of 2-bit saturating counters that the fetch stage reads for prediction. Each resolved branch trains the table and raises a one-cycle mispredict pulse to the hazard/flush logic.

## Interface

- XLEN, 64, operand and PC width
- BHT_DEPTH, 64, number of counter entries; power of two, ≥ 2
- IDX_W, $clog2(BHT_DEPTH), table index width; derived, not overridden

Ports:

- i_riscv_core_clk  in  1  clock; all state updates on rising edge
- i_riscv_core_rst  in  1  reset; synchronous, active-high
- i_riscv_bru_fetch_pc  in  XLEN  fetch PC for prediction lookup
- o_riscv_bru_pred_taken  out  1  combinational prediction for fetch_pc
- i_riscv_bru_valid  in  1  execute-stage instruction valid
- i_riscv_bru_stall  in  1  execute stage stalled; input not consumed
- i_riscv_bru_cond  in  4  bit 3 = branch enable; [2:0] = funct3
- i_riscv_bru_rs1data  in  XLEN  signed operand 1
- i_riscv_bru_rs2data  in  XLEN  signed operand 2
- i_riscv_bru_pc  in  XLEN  PC of the branch being resolved
- i_riscv_bru_pred_taken  in  1  prediction made at fetch, carried down the pipe
- o_riscv_bru_res_valid  out  1  registered; a branch resolved last cycle
- o_riscv_bru_taken  out  1  registered resolved direction
- o_riscv_bru_mispredict  out  1  registered one-cycle pulse

## Operation

- Index = pc[IDX_W+1:2] for both fetch lookup and resolve. Bits [1:0] are ignored.
- Lookup: o_riscv_bru_pred_taken = counter[fetch index][1]. It is purely combinational.
- Accept: acc = valid & ~stall & cond[3] & (cond[2:0] ∈ {000,001,100,101,110,111}).
- Comparisons: EQ is rs1 == rs2. LT is a signed XLEN compare. LTU is an unsigned XLEN compare.
- funct3 mapping: BEQ 000 → EQ; BNE 001 → ~EQ; BLT 100 → LT; BGE 101 → ~LT; BLTU 110 → LTU; BGEU 111 → ~LTU.
- funct3 010 or 011 with cond[3]=1: not accepted. The table is not updated and no outputs pulse.
- On an accept edge:
  - res_valid ← 1
  - taken ← computed direction
  - mispredict ← (taken ≠ i_riscv_bru_pred_taken)
  - counter[resolve index] is updated as a saturating counter: taken → min(c+1, 3); not taken → max(c−1, 0).
- On a non-accept edge (including stall): res_valid ← 0 and mispredict ← 0. o_riscv_bru_taken holds its last value.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.

## Timing

- Reset (synchronous, high for ≥ 1 edge):
  - all counters ← 01
  - res_valid, taken, mispredict ← 0
  - perf counters ← 0 (when compiled in)
- While reset is high, accept is suppressed.
- Reset asserted during an accept cycle: reset wins. No update occurs and there is no pulse.
- Latency: inputs in cycle N → outputs valid in cycle N+1. mispredict is high for exactly one cycle per mispredicted branch.
- Back-to-back accepts are allowed every cycle, giving one resolution per cycle.
- Table write lands at the end of cycle N. A fetch lookup in cycle N+1 sees the new value.
- Same index read and written in cycle N: lookup returns the old value. There is no bypass.
- Stall held for multiple cycles: no table change and outputs stay deasserted. On release, the held instruction is accepted once.

## Configuration

- RISCV_BRU_PERF_EN defined: adds two ports.
  - o_riscv_bru_br_count (out, 32): increments on each accept.
  - o_riscv_bru_miss_count (out, 32): increments on each accept with mispredict.
  - Both counters saturate at 32'hFFFF_FFFF, update on the same edge as the outputs, and reset to 0.
- RISCV_BRU_PERF_EN undefined: these ports and registers do not exist. All other behaviour is identical.

## Test plan

- Reset, then sweep fetch_pc over all BHT_DEPTH indices → pred_taken = 0 everywhere. All outputs are 0 after reset.
- BLT with rs1 = −1 (all ones) and rs2 = 1, pred 0 → next cycle taken = 1, mispredict = 1. BLTU with the same operands, pred 0 → taken = 0, mispredict = 0.
- BEQ/BNE/BGE/BGEU on rs1 = rs2 = 64'h8000_0000_0000_0000 → taken = 1, 0, 1, 1 respectively.
- Four consecutive taken BEQs at pc = 0x100:
  - counter goes 01 → 10 → 11 → 11 (saturates)
  - pred_taken at fetch_pc = 0x100 becomes 1 the cycle after the first resolve
  - two not-taken resolves then return pred_taken to 0
- cond = 4'b1010 with valid, and any branch with stall = 1 → res_valid = 0, mispredict = 0, no counter change. The stalled branch is accepted exactly once after stall drops.
- With RISCV_BRU_PERF_EN: 10 branches, 3 mispredicted → br_count = 10, miss_count = 3. A preloaded br_count of 32'hFFFF_FFFF stays at 32'hFFFF_FFFF on a further accept.

Source files
------------

// File: rtl/riscv_branch_unit.sv
// riscv_branch_unit: RV64 branch resolution with a direct-mapped 2-bit BHT.
// Optional perf counters are compiled in with RISCV_BRU_PERF_EN.
module riscv_branch_unit #(
  parameter int XLEN      = 64,
  parameter int BHT_DEPTH = 64
) (
  input  logic            i_riscv_core_clk,
  input  logic            i_riscv_core_rst,
  input  logic [XLEN-1:0] i_riscv_bru_fetch_pc,
  output logic            o_riscv_bru_pred_taken,
  input  logic            i_riscv_bru_valid,
  input  logic            i_riscv_bru_stall,
  input  logic [3:0]      i_riscv_bru_cond,
  input  logic [XLEN-1:0] i_riscv_bru_rs1data,
  input  logic [XLEN-1:0] i_riscv_bru_rs2data,
  input  logic [XLEN-1:0] i_riscv_bru_pc,
  input  logic            i_riscv_bru_pred_taken,
  output logic            o_riscv_bru_res_valid,
  output logic            o_riscv_bru_taken,
  output logic            o_riscv_bru_mispredict
`ifdef RISCV_BRU_PERF_EN
  ,
  output logic [31:0]     o_riscv_bru_br_count,
  output logic [31:0]     o_riscv_bru_miss_count
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht_q [BHT_DEPTH];
  logic             res_valid_q;
  logic             taken_q;
  logic             mispred_q;

  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] res_idx;
  logic             eq;
  logic             lt;
  logic             ltu;
  logic             f3_ok;
  logic             dir;
  logic             acc;
  logic             mispred_d;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_d;
  logic             unused_pc;

  assign fetch_idx = i_riscv_bru_fetch_pc[IDX_W+1:2];
  assign res_idx   = i_riscv_bru_pc[IDX_W+1:2];

  assign unused_pc = ^{i_riscv_bru_fetch_pc[XLEN-1:IDX_W+2],
                       i_riscv_bru_fetch_pc[1:0],
                       i_riscv_bru_pc[XLEN-1:IDX_W+2],
                       i_riscv_bru_pc[1:0]};

  // Lookup reads the registered table: no bypass from a same-cycle write.
  assign o_riscv_bru_pred_taken = bht_q[fetch_idx][1];

  assign eq  = i_riscv_bru_rs1data == i_riscv_bru_rs2data;
  assign lt  = $signed(i_riscv_bru_rs1data) < $signed(i_riscv_bru_rs2data);
  assign ltu = i_riscv_bru_rs1data < i_riscv_bru_rs2data;

  always_comb begin
    f3_ok = 1'b1;
    dir   = 1'b0;
    case (i_riscv_bru_cond[2:0])
      3'b000:  dir = eq;
      3'b001:  dir = ~eq;
      3'b100:  dir = lt;
      3'b101:  dir = ~lt;
      3'b110:  dir = ltu;
      3'b111:  dir = ~ltu;
      default: f3_ok = 1'b0;
    endcase
  end

  assign acc = i_riscv_bru_valid & ~i_riscv_bru_stall
             & i_riscv_bru_cond[3] & f3_ok
             & ~i_riscv_core_rst;

  assign mispred_d = acc & (dir != i_riscv_bru_pred_taken);

  assign ctr_cur = bht_q[res_idx];

  always_comb begin
    ctr_d = ctr_cur;
    if (dir) begin
      if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge i_riscv_core_clk) begin
    if (i_riscv_core_rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
      res_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      mispred_q   <= 1'b0;
    end else begin
      res_valid_q <= acc;
      mispred_q   <= mispred_d;
      if (acc) begin
        taken_q        <= dir;
        bht_q[res_idx] <= ctr_d;
      end
    end
  end

  assign o_riscv_bru_res_valid  = res_valid_q;
  assign o_riscv_bru_taken      = taken_q;
  assign o_riscv_bru_mispredict = mispred_q;

`ifdef RISCV_BRU_PERF_EN
  logic [31:0] br_cnt_q;
  logic [31:0] br_cnt_d;
  logic [31:0] miss_cnt_q;
  logic [31:0] miss_cnt_d;

  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (acc && br_cnt_q != 32'hFFFF_FFFF)
      br_cnt_d = br_cnt_q + 32'd1;
    if (mispred_d && miss_cnt_q != 32'hFFFF_FFFF)
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge i_riscv_core_clk) begin
    if (i_riscv_core_rst) begin
      br_cnt_q   <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign o_riscv_bru_br_count   = br_cnt_q;
  assign o_riscv_bru_miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_branch_unit.sv
// Directed self-checking bench for riscv_branch_unit.
// Perf-counter checks are built only with RISCV_BRU_PERF_EN.
module tb_riscv_branch_unit;

  localparam int XLEN = 64;
  localparam int DEPTH = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] fetch_pc;
  logic            pred_o;
  logic            valid;
  logic            stall;
  logic [3:0]      cond;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] bpc;
  logic            pred_i;
  logic            res_valid;
  logic            taken;
  logic            mispred;
`ifdef RISCV_BRU_PERF_EN
  logic [31:0]     br_count;
  logic [31:0]     miss_count;
`endif

  int n_checks = 0;
  int n_fail = 0;

  riscv_branch_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH)) dut (
    .i_riscv_core_clk       (clk),
    .i_riscv_core_rst       (rst),
    .i_riscv_bru_fetch_pc   (fetch_pc),
    .o_riscv_bru_pred_taken (pred_o),
    .i_riscv_bru_valid      (valid),
    .i_riscv_bru_stall      (stall),
    .i_riscv_bru_cond       (cond),
    .i_riscv_bru_rs1data    (rs1),
    .i_riscv_bru_rs2data    (rs2),
    .i_riscv_bru_pc         (bpc),
    .i_riscv_bru_pred_taken (pred_i),
    .o_riscv_bru_res_valid  (res_valid),
    .o_riscv_bru_taken      (taken),
    .o_riscv_bru_mispredict (mispred)
`ifdef RISCV_BRU_PERF_EN
    ,
    .o_riscv_bru_br_count   (br_count),
    .o_riscv_bru_miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic s,
                       input logic [3:0] c,
                       input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] pc,
                       input logic p);
    valid = v; stall = s; cond = c;
    rs1 = a; rs2 = b; bpc = pc; pred_i = p;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, '0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    fetch_pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_res_valid: got %b expected 0", res_valid);
    end
    n_checks++;
    if (taken !== 1'b0) begin
      n_fail++; $display("FAIL rst_taken: got %b expected 0", taken);
    end
    n_checks++;
    if (mispred !== 1'b0) begin
      n_fail++; $display("FAIL rst_mispred: got %b expected 0", mispred);
    end
    for (int i = 0; i < DEPTH; i++) begin
      fetch_pc = XLEN'(i) << 2;
      #1;
      n_checks++;
      if (pred_o !== 1'b0) begin
        n_fail++; $display("FAIL rst_pred idx %0d: got %b expected 0", i, pred_o);
      end
    end
  endtask

  task automatic test_compare();
    logic [3:0] cv [4] = '{4'b1000, 4'b1001, 4'b1101, 4'b1111};
    logic       tv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [XLEN-1:0] m;
    m = 64'h8000_0000_0000_0000;
    do_reset();
    drive(1'b1, 1'b0, 4'b1100, '1, 64'd1, 64'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({res_valid, taken, mispred} !== 3'b111) begin
      n_fail++; $display("FAIL blt_neg: got %b expected 111", {res_valid, taken, mispred});
    end
    drive(1'b1, 1'b0, 4'b1110, '1, 64'd1, 64'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({res_valid, taken, mispred} !== 3'b100) begin
      n_fail++; $display("FAIL bltu_neg: got %b expected 100", {res_valid, taken, mispred});
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, cv[k], m, m, 64'h10, 1'b1);
      @(negedge clk);
      n_checks++;
      if ({res_valid, taken, mispred} !== {1'b1, tv[k], ~tv[k]}) begin
        n_fail++;
        $display("FAIL eq_ops cond %b: got %b expected %b", cv[k],
                 {res_valid, taken, mispred}, {1'b1, tv[k], ~tv[k]});
      end
    end
    idle();
  endtask

  task automatic test_bht_train();
    logic pre [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic post [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    fetch_pc = 64'h100;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1'b1, 1'b0, 4'b1000, 64'd5, 64'd5, 64'h100, 1'b1);
      else       drive(1'b1, 1'b0, 4'b1001, 64'd5, 64'd5, 64'h100, 1'b1);
      #1;
      n_checks++;
      if (pred_o !== pre[k]) begin
        n_fail++; $display("FAIL bht_same_cycle step %0d: got %b expected %b", k, pred_o, pre[k]);
      end
      @(negedge clk);
      n_checks++;
      if (pred_o !== post[k]) begin
        n_fail++; $display("FAIL bht_after step %0d: got %b expected %b", k, pred_o, post[k]);
      end
      n_checks++;
      if (mispred !== (k >= 4)) begin
        n_fail++; $display("FAIL bht_mispred step %0d: got %b expected %b", k, mispred, k >= 4);
      end
    end
    idle();
  endtask

  task automatic test_stall_illegal();
    do_reset();
    fetch_pc = 64'h40;
    drive(1'b1, 1'b0, 4'b1000, 64'd1, 64'd1, 64'h80, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({res_valid, taken} !== 2'b11) begin
      n_fail++; $display("FAIL pre_taken: got %b expected 11", {res_valid, taken});
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, (k == 0) ? 4'b1010 : 4'b1011, 64'd1, 64'd1, 64'h40, 1'b0);
      @(negedge clk);
      n_checks++;
      if ({res_valid, taken, mispred, pred_o} !== 4'b0100) begin
        n_fail++;
        $display("FAIL illegal_f3 %0d: got %b expected 0100", k, {res_valid, taken, mispred, pred_o});
      end
    end
    drive(1'b1, 1'b1, 4'b1000, 64'd1, 64'd1, 64'h40, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({res_valid, taken, mispred, pred_o} !== 4'b0100) begin
        n_fail++;
        $display("FAIL stall %0d: got %b expected 0100", k, {res_valid, taken, mispred, pred_o});
      end
    end
    stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({res_valid, taken, mispred, pred_o} !== 4'b1111) begin
      n_fail++; $display("FAIL stall_release: got %b expected 1111", {res_valid, taken, mispred, pred_o});
    end
    idle();
    @(negedge clk);
    n_checks++;
    if ({res_valid, mispred, pred_o} !== 3'b001) begin
      n_fail++; $display("FAIL after_release: got %b expected 001", {res_valid, mispred, pred_o});
    end
    drive(1'b1, 1'b0, 4'b1001, 64'd1, 64'd1, 64'h40, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({res_valid, taken, mispred, pred_o} !== 4'b1010) begin
      n_fail++; $display("FAIL single_accept: got %b expected 1010", {res_valid, taken, mispred, pred_o});
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [3:0]      cv [5] = '{4'b1001, 4'b1000, 4'b1100, 4'b1111, 4'b1101};
    logic [XLEN-1:0] av [5] = '{64'd3, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'd2,
                                64'h7FFF_FFFF_FFFF_FFFF};
    logic [XLEN-1:0] bv [5] = '{64'd4, 64'd4, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF,
                                64'h8000_0000_0000_0000};
    logic            pv [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic            tv [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic            mv [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, cv[k], av[k], bv[k], XLEN'(k) << 2, pv[k]);
      @(negedge clk);
      n_checks++;
      if ({res_valid, taken, mispred} !== {1'b1, tv[k], mv[k]}) begin
        n_fail++;
        $display("FAIL b2b %0d: got %b expected %b", k,
                 {res_valid, taken, mispred}, {1'b1, tv[k], mv[k]});
      end
    end
    idle();
    @(negedge clk);
    n_checks++;
    if ({res_valid, taken, mispred} !== 3'b010) begin
      n_fail++; $display("FAIL b2b_idle: got %b expected 010", {res_valid, taken, mispred});
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    fetch_pc = 64'h40;
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'b1000, 64'd1, 64'd1, 64'h40, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    n_checks++;
    if ({res_valid, taken, mispred, pred_o} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_priority: got %b expected 0000", {res_valid, taken, mispred, pred_o});
    end
  endtask

`ifdef RISCV_BRU_PERF_EN
  task automatic test_perf();
    do_reset();
    n_checks++;
    if ({br_count, miss_count} !== 64'd0) begin
      n_fail++; $display("FAIL perf_rst: got %h/%h expected 0/0", br_count, miss_count);
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 4'b1000, 64'd7, 64'd7, XLEN'(k) << 2, (k >= 3));
      @(negedge clk);
    end
    idle();
    @(negedge clk);
    n_checks++;
    if (br_count !== 32'd10) begin
      n_fail++; $display("FAIL perf_br: got %0d expected 10", br_count);
    end
    n_checks++;
    if (miss_count !== 32'd3) begin
      n_fail++; $display("FAIL perf_miss: got %0d expected 3", miss_count);
    end
    dut.br_cnt_q = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 4'b1000, 64'd7, 64'd7, 64'h0, 1'b1);
    @(negedge clk);
    idle();
    n_checks++;
    if (br_count !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL perf_sat: got %h expected ffffffff", br_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_compare();
    test_bht_train();
    test_stall_illegal();
    test_back_to_back();
    test_reset_priority();
`ifdef RISCV_BRU_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
